// File: rtl/seg7_value_display.sv
// Latches a 32-bit value on a strobe and scans it as hex digits onto a common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining SEG7_LEADING_ZERO_BLANK_EN.
module seg7_value_display #(
  parameter int unsigned DIGITS   = 8,
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       value_in,
  input  logic              value_valid,
  input  logic              hold,
  input  logic              done_in,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg,
  output logic              dp,
  output logic              upd_pulse
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CntMax = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IdxMax = IW'(DIGITS - 1);

  logic [31:0]       r_value;
  logic              r_done;
  logic [CW-1:0]     r_scan_cnt;
  logic [IW-1:0]     r_digit_idx;

  logic [31:0]       w_shifted;
  logic [3:0]        w_nibble;
  logic              w_blank;
  logic [DIGITS-1:0] w_an_sel;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    w_shifted = r_value >> (4 * r_digit_idx);
    w_nibble  = w_shifted[3:0];
    w_an_sel  = ~(DIGITS'(1) << r_digit_idx);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit 0 is never blanked so a zero value still shows a single "0".
    w_blank   = (r_digit_idx != '0) && (w_shifted == 32'd0);
`else
    w_blank   = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_value     <= '0;
      r_done      <= 1'b0;
      r_scan_cnt  <= '0;
      r_digit_idx <= '0;
      an          <= '1;
      seg         <= 7'h7F;
      dp          <= 1'b1;
      upd_pulse   <= 1'b0;
    end else begin
      if (value_valid && !hold) begin
        r_value   <= value_in;
        upd_pulse <= 1'b1;
      end else begin
        upd_pulse <= 1'b0;
      end
      r_done <= done_in;

      if (r_scan_cnt == CntMax) begin
        r_scan_cnt  <= '0;
        r_digit_idx <= (r_digit_idx == IdxMax) ? '0 : r_digit_idx + 1'b1;
      end else begin
        r_scan_cnt  <= r_scan_cnt + 1'b1;
      end

      // Output stage lags digit_idx/value_reg by one cycle.
      an  <= w_blank ? '1 : w_an_sel;
      seg <= w_blank ? 7'h7F : hex_to_seg(w_nibble);
      dp  <= !((r_digit_idx == '0) && r_done);
    end
  end

endmodule

// File: tb/tb_seg7_value_display.sv
// Scoreboard bench for seg7_value_display (SCAN_DIV = 4): a cycle model pushes expected outputs,
// which are popped and compared after each clock edge.
module tb_seg7_value_display;

  localparam int unsigned DIGITS   = 8;
  localparam int unsigned SCAN_DIV = 4;

  localparam logic [6:0] SegTab [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       upd;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] value_in;
  logic        value_valid;
  logic        hold;
  logic        done_in;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        upd_pulse;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  exp_t        sb_q[$];
  logic [31:0] m_val;
  logic        m_done;
  int unsigned m_cnt;
  int unsigned m_idx;

  seg7_value_display #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .value_in   (value_in),
    .value_valid(value_valid),
    .hold       (hold),
    .done_in    (done_in),
    .an         (an),
    .seg        (seg),
    .dp         (dp),
    .upd_pulse  (upd_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one clock: the model predicts what the edge produces, then the DUT is compared.
  task automatic tick();
    exp_t        e;
    logic [31:0] sh;
    @(posedge clk);
    if (reset) begin
      e      = '{an: 8'hFF, seg: 7'h7F, dp: 1'b1, upd: 1'b0};
      m_val  = '0;
      m_done = 1'b0;
      m_cnt  = 0;
      m_idx  = 0;
    end else begin
      sh         = m_val >> (4 * m_idx);
      e.an       = 8'hFF;
      e.an[m_idx] = 1'b0;
      e.seg      = SegTab[sh[3:0]];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (m_idx != 0 && sh == 0) begin
        e.an  = 8'hFF;
        e.seg = 7'h7F;
      end
`endif
      e.dp  = !(m_idx == 0 && m_done);
      e.upd = value_valid && !hold;
      if (value_valid && !hold) m_val = value_in;
      m_done = done_in;
      if (m_cnt == SCAN_DIV - 1) begin
        m_cnt = 0;
        m_idx = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    sb_q.push_back(e);
    #1;
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check("an", {24'd0, an}, {24'd0, e.an});
      check("seg", {25'd0, seg}, {25'd0, e.seg});
      check("dp", {31'd0, dp}, {31'd0, e.dp});
      check("upd_pulse", {31'd0, upd_pulse}, {31'd0, e.upd});
      check("an_onehot0", {31'd0, ($countones(~an) <= 1)}, 32'd1);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [31:0] v);
    value_in    = v;
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  initial begin
    bit found;
    reset       = 1'b1;
    value_in    = '0;
    value_valid = 1'b0;
    hold        = 1'b0;
    done_in     = 1'b0;

    run(3);
    check("reset_an", {24'd0, an}, 32'hFF);
    check("reset_seg", {25'd0, seg}, 32'h7F);
    reset = 1'b0;
    run(40);

    strobe(32'h12345678);
    run(40);

    hold = 1'b1;
    strobe(32'hDEADBEEF);
    strobe(32'hDEADBEEF);
    run(8);
    hold = 1'b0;
    strobe(32'hDEADBEEF);
    run(36);

    done_in = 1'b1;
    run(36);
    done_in = 1'b0;
    run(12);

    // Continuous strobe across several scan wraps, with occasional hold.
    value_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      value_in = $urandom;
      hold     = (i % 7 == 3);
      tick();
    end
    value_valid = 1'b0;
    hold        = 1'b0;
    run(34);

    // Reset while digit 5 is on the display.
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (an == 8'hDF) found = 1'b1;
      else tick();
    end
    check("found_digit5", {31'd0, found}, 32'd1);
    reset = 1'b1;
    tick();
    check("midframe_reset_an", {24'd0, an}, 32'hFF);
    reset = 1'b0;
    run(36);

    strobe(32'h000000A5);
    run(36);
    strobe(32'h0);
    run(36);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
